fetch_stage: RTL and testbench

//   Instruction fetch stage feeding the CPU controller/decoder. Owns the PC, drives the

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus between imem, fetch_stage and decode.
// Ports (signals): imem_addr/imem_rdata (combinational imem read), redirect_valid/redirect_pc
// (jump/branch), instr_valid/instr_ready/instr/instr_pc (decode handshake), halted, fetch_count.
// master = fetch_stage side, slave = imem/decode/controller side.
interface fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               halted;
    logic [15:0]        fetch_count;
    modport master (
        output imem_addr, instr_valid, instr, instr_pc, halted, fetch_count,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_addr, instr_valid, instr, instr_pc, halted, fetch_count,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, reads imem, buffers {pc, word} in a small FIFO for decode.
// Ports: clk, rst (async active-high), fch (fetch_if.master: imem read, redirect,
// instr valid/ready handshake, halted status, fetch_count of enqueued words).
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [6:0]        HALT_OP  = 7'h7F
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  fch
);
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PW:0]        cnt_q, cnt_d;
    logic [PW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic               halted_q, halted_d;
    logic [15:0]        fcnt_q, fcnt_d;
    logic [INSTR_W-1:0] last_instr_q, last_instr_d;
    logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
    logic [INSTR_W-1:0] buf_instr_q [DEPTH];
    logic [ADDR_W-1:0]  buf_pc_q [DEPTH];
    logic               valid, deq, enq, is_halt;
    assign valid   = cnt_q != '0;
    assign deq     = valid & fch.instr_ready;
    // a full FIFO still accepts a word when the head leaves on the same edge
    assign enq     = ~fch.redirect_valid & ~halted_q & ((cnt_q < (PW+1)'(DEPTH)) | deq);
    assign is_halt = fch.imem_rdata[INSTR_W-1 -: 7] == HALT_OP;
    always_comb begin
        pc_d         = fch.redirect_valid ? fch.redirect_pc : (enq & ~is_halt) ? pc_q + 1'b1 : pc_q;
        cnt_d        = fch.redirect_valid ? '0 : cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
        rd_d         = fch.redirect_valid ? '0 : rd_q + PW'(deq);
        wr_d         = fch.redirect_valid ? '0 : wr_q + PW'(enq);
        halted_d     = fch.redirect_valid ? 1'b0 : halted_q | (enq & is_halt);
        fcnt_d       = fcnt_q + 16'(enq);
        // remember what decode last saw so the outputs hold while the FIFO is empty
        last_instr_d = valid ? buf_instr_q[rd_q] : last_instr_q;
        last_pc_d    = valid ? buf_pc_q[rd_q] : last_pc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            halted_q     <= 1'b0;
            fcnt_q       <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            halted_q     <= halted_d;
            fcnt_q       <= fcnt_d;
            last_instr_q <= last_instr_d;
            last_pc_q    <= last_pc_d;
        end
    end
    // storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_instr_q[wr_q] <= fch.imem_rdata;
            buf_pc_q[wr_q]    <= pc_q;
        end
    end
    assign fch.imem_addr   = pc_q;
    assign fch.instr_valid = valid;
    assign fch.instr       = valid ? buf_instr_q[rd_q] : last_instr_q;
    assign fch.instr_pc    = valid ? buf_pc_q[rd_q] : last_pc_q;
    assign fch.halted      = halted_q;
    assign fch.fetch_count = fcnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; expected {pc, word} stream queued at
// stimulus time and popped on every accepted decode handshake.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] mem [65536];
    logic [31:0] exp_q [$];
    int n_chk = 0;
    int n_pass = 0;
    fetch_if f ();
    fetch_stage dut (.clk(clk), .rst(rst), .fch(f));
    always #5 clk = ~clk;
    assign f.imem_rdata = mem[f.imem_addr];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push_stream(input logic [15:0] start, input int n);
        logic [15:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 16'(i);
            exp_q.push_back({pc, mem[pc]});
        end
    endtask
    task automatic do_reset(input logic rdy, input int n);
        @(posedge clk);
        #3;
        rst = 1'b1;
        f.instr_ready = rdy;
        f.redirect_valid = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", 32'(f.instr_valid), 0);
        check("rst_instr", 32'(f.instr), 0);
        check("rst_instr_pc", 32'(f.instr_pc), 0);
        check("rst_halted", 32'(f.halted), 0);
        check("rst_fetch_count", 32'(f.fetch_count), 0);
        check("rst_imem_addr", 32'(f.imem_addr), 0);
        tick();
        rst = 1'b0;
        push_stream(16'h0000, n);
        check("rel_valid", 32'(f.instr_valid), 0);
    endtask
    task automatic redirect_to(input logic [15:0] pc, input int n);
        f.redirect_valid = 1'b1;
        f.redirect_pc = pc;
        exp_q.delete();
        push_stream(pc, n);
        tick();
        f.redirect_valid = 1'b0;
    endtask
    task automatic restart_checks();
        tick();
        check("start_valid", 32'(f.instr_valid), 1);
        check("start_pc0", 32'(f.instr_pc), 0);
        check("start_instr0", 32'(f.instr), 32'h0100);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("start_pc_seq", 32'(f.instr_pc), 32'(i));
        end
    endtask
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && f.instr_valid && f.instr_ready && !f.redirect_valid) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_pc_instr", {f.instr_pc, f.instr}, e);
                end
            end
        end
    end
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(16'h0100 + i);
        f.instr_ready = 1'b1;
        f.redirect_valid = 1'b0;
        f.redirect_pc = '0;
        // 1: reset and free-running fetch
        do_reset(1'b1, 64);
        restart_checks();
        // 2: back-pressure fills the FIFO, then drains without gaps
        do_reset(1'b0, 64);
        repeat (5) tick();
        check("bp_valid", 32'(f.instr_valid), 1);
        check("bp_instr_pc", 32'(f.instr_pc), 0);
        check("bp_imem_addr", 32'(f.imem_addr), 2);
        check("bp_fetch_count", 32'(f.fetch_count), 2);
        f.instr_ready = 1'b1;
        repeat (6) tick();
        check("bp_drain_pc", 32'(f.instr_pc), 6);
        // 3: redirect while full
        f.instr_ready = 1'b0;
        repeat (3) tick();
        redirect_to(16'h0040, 64);
        f.instr_ready = 1'b1;
        check("rd_flush_valid", 32'(f.instr_valid), 0);
        tick();
        check("rd_valid", 32'(f.instr_valid), 1);
        check("rd_pc40", 32'(f.instr_pc), 32'h40);
        tick();
        check("rd_pc41", 32'(f.instr_pc), 32'h41);
        // 4: HALT at address 3
        mem[3] = 16'hFE00;
        do_reset(1'b1, 4);
        repeat (4) tick();
        check("halt_set", 32'(f.halted), 1);
        check("halt_pc_stuck", 32'(f.imem_addr), 3);
        check("halt_head", 32'(f.instr_pc), 3);
        check("halt_fetch_count", 32'(f.fetch_count), 4);
        tick();
        check("halt_drained", 32'(f.instr_valid), 0);
        check("halt_hold_instr", 32'(f.instr), 32'hFE00);
        check("halt_hold_pc", 32'(f.instr_pc), 3);
        repeat (3) tick();
        check("halt_no_fetch", 32'(f.fetch_count), 4);
        check("halt_sb_done", 32'(exp_q.size()), 0);
        redirect_to(16'h0000, 4);
        check("halt_cleared", 32'(f.halted), 0);
        check("halt_rd_addr", 32'(f.imem_addr), 0);
        repeat (6) tick();
        check("halt_again", 32'(f.halted), 1);
        check("halt_again_sb", 32'(exp_q.size()), 0);
        mem[3] = 16'h0103;
        // 5: PC wrap
        do_reset(1'b1, 0);
        redirect_to(16'hFFFF, 64);
        check("wrap_fc0", 32'(f.fetch_count), 0);
        tick();
        check("wrap_pc_ffff", 32'(f.instr_pc), 32'hFFFF);
        check("wrap_instr", 32'(f.instr), 32'h00FF);
        check("wrap_addr0", 32'(f.imem_addr), 0);
        check("wrap_fc1", 32'(f.fetch_count), 1);
        tick();
        check("wrap_pc0", 32'(f.instr_pc), 0);
        check("wrap_fc2", 32'(f.fetch_count), 2);
        // 6: asynchronous reset mid-stream, then restart
        repeat (3) tick();
        do_reset(1'b1, 64);
        restart_checks();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
